pwm_decoder: RTL and testbench

- Receive side of the team's PWM link: recovers the N-bit duty word from a PWM waveform produced by `pwm` driven by `pulse_generator` step pulses.
- Samples the input once per step pulse, measures high time and period between rising edges, and reports duty when the period is exactly 2^N steps.
- Sits next to the `pwm` block for loopback self-test and external PWM capture.

---
 rtl/pwm_decoder.sv | 164 ++++++++++++++++
 tb/tb_pwm_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM receive decoder: recovers an N-bit duty word from a PWM waveform sampled on step strobes.
// Reports duty on every exact 2^N-sample period and flags malformed periods or a stuck-high line.
module pwm_decoder #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic         in,
  output logic [N-1:0] duty,
  output logic         valid,
  output logic         err,
  output logic         locked
);

  localparam int unsigned CW = N + 1;
  localparam logic [CW-1:0] PERIOD = {1'b1, {N{1'b0}}};
  localparam logic [CW-1:0] ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, s_q;
  logic          prev_q, prev_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] scnt_q, scnt_d;
  logic [N-1:0]  duty_q, duty_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;

  logic          sample, rise, fall, close, tmo;
  logic [CW-1:0] scnt_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (&x) ? x : x + ONE;
  endfunction

  // Two-flop synchronizer runs every clk, independent of ena
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= in;
      s_q     <= sync1_q;
    end
  end

  assign sample   = step & ena;
  assign rise     = s_q & ~prev_q;
  assign fall     = ~s_q & prev_q;
  assign scnt_inc = (s_q != prev_q) ? ONE : scnt_q + ONE;
  assign close    = sample && (state_q == LOW) && rise;
  // An edge report always wins over a stable-level timeout on the same sample
  assign tmo      = sample && (scnt_inc == PERIOD) && !close;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sample) begin
      unique case (state_q)
        IDLE:    if (rise) state_d = HIGH;
        HIGH:    if (fall) state_d = LOW;
        LOW:     if (rise) state_d = HIGH;
        default: state_d = IDLE;
      endcase
      if (tmo) state_d = IDLE;
    end
  end

  always_comb begin
    prev_d   = prev_q;
    hcnt_d   = hcnt_q;
    pcnt_d   = pcnt_q;
    scnt_d   = scnt_q;
    duty_d   = duty_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (sample) begin
      prev_d = s_q;
      scnt_d = (scnt_inc == PERIOD) ? '0 : scnt_inc;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            hcnt_d = ONE;
            pcnt_d = ONE;
          end
        end
        HIGH: begin
          pcnt_d = sat_inc(pcnt_q);
          if (s_q) hcnt_d = sat_inc(hcnt_q);
        end
        LOW: begin
          if (rise) begin
            if (pcnt_q == PERIOD) begin
              duty_d   = hcnt_q[N-1:0];
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              locked_d = 1'b0;
            end
            hcnt_d = ONE;
            pcnt_d = ONE;
          end else begin
            pcnt_d = sat_inc(pcnt_q);
          end
        end
        default: ;
      endcase
      // A full period at one level: low means duty 0, high is unrepresentable
      if (tmo) begin
        if (s_q) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
        end else begin
          duty_d   = '0;
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= 1'b0;
      hcnt_q   <= '0;
      pcnt_q   <= '0;
      scnt_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      hcnt_q   <= hcnt_d;
      pcnt_q   <= pcnt_d;
      scnt_q   <= scnt_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign duty   = duty_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: directed scenarios plus random waveforms checked against a
// history-based model that measures periods between rising edges over recorded samples.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst, ena, step, din;
  logic [3:0] duty;
  logic       valid, err, locked;

  int checks = 0;
  int errors = 0;

  pwm_decoder #(.N(4)) dut (
    .clk(clk), .rst(rst), .ena(ena), .step(step), .in(din),
    .duty(duty), .valid(valid), .err(err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sample history, armed rising-edge index, stable-run length
  bit         hist[$];
  int         rise_idx;
  bit         armed;
  bit         m_prev;
  int         run_len;
  logic [3:0] m_duty;
  bit         m_locked, m_valid, m_err;
  int         ph;

  task automatic model_reset();
    hist.delete();
    rise_idx = 0;
    armed    = 1'b0;
    m_prev   = 1'b0;
    run_len  = 0;
    m_duty   = 4'd0;
    m_locked = 1'b0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_sample(input bit v);
    int idx, per, ones;
    m_valid = 1'b0;
    m_err   = 1'b0;
    run_len = (v != m_prev) ? 1 : run_len + 1;
    hist.push_back(v);
    idx = hist.size() - 1;
    if (v && !m_prev) begin
      if (armed) begin
        per = idx - rise_idx;
        if (per == 16) begin
          ones = 0;
          for (int i = rise_idx; i < idx; i++) ones += int'(hist[i]);
          m_duty   = 4'(ones);
          m_valid  = 1'b1;
          m_locked = 1'b1;
        end else begin
          m_err    = 1'b1;
          m_locked = 1'b0;
        end
      end
      armed    = 1'b1;
      rise_idx = idx;
    end else if (run_len % 16 == 0) begin
      if (v) begin
        m_err    = 1'b1;
        m_locked = 1'b0;
      end else begin
        m_duty   = 4'd0;
        m_valid  = 1'b1;
        m_locked = 1'b1;
      end
      armed = 1'b0;
    end
    m_prev = v;
  endtask

  // One step: settle input through the synchronizer, strobe, check the result and the gap cycle
  task automatic do_step(input bit v, input bit en);
    @(negedge clk) din = v;
    repeat (2) @(negedge clk);
    step = 1'b1;
    ena  = en;
    @(negedge clk) step = 1'b0;
    if (en) model_sample(v);
    else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    check("valid",  32'(valid),  32'(m_valid));
    check("err",    32'(err),    32'(m_err));
    check("duty",   32'(duty),   32'(m_duty));
    check("locked", 32'(locked), 32'(m_locked));
    @(negedge clk);
    check("valid_gap", 32'(valid), 32'd0);
    check("err_gap",   32'(err),   32'd0);
  endtask

  task automatic wave(input int d, input int n, input bit en);
    for (int k = 0; k < n; k++) begin
      do_step(ph < d, en);
      ph = (ph + 1) % 16;
    end
  endtask

  task automatic irregular(input int per, input int hi);
    for (int k = 0; k < per; k++) do_step(k < hi, 1'b1);
    ph = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk) rst = 1'b1;
    #1;
    check("rst_duty",   32'(duty),   32'd0);
    check("rst_valid",  32'(valid),  32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    @(negedge clk) rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst  = 1'b1;
    ena  = 1'b0;
    step = 1'b0;
    din  = 1'b0;
    ph   = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_duty",   32'(duty),   32'd0);
    check("reset_valid",  32'(valid),  32'd0);
    check("reset_err",    32'(err),    32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    @(negedge clk) rst = 1'b0;

    // Steady duty 5
    wave(5, 48, 1'b1);
    check("d5_duty", 32'(duty), 32'd5);
    check("d5_lock", 32'(locked), 32'd1);

    // Sweep 1..15
    for (int d = 1; d < 16; d++) wave(d, 32, 1'b1);
    check("sweep_last", 32'(duty), 32'd15);

    // Constant low line
    wave(0, 48, 1'b1);
    check("d0_duty", 32'(duty), 32'd0);
    check("d0_lock", 32'(locked), 32'd1);

    // Short periods then exact 16 with 4 high
    irregular(12, 4);
    irregular(12, 4);
    irregular(16, 4);
    irregular(16, 4);
    do_step(1'b1, 1'b1);
    check("p16_duty", 32'(duty), 32'd4);
    ph = 1;

    // Stuck high, then recover at duty 7
    for (int k = 0; k < 20; k++) do_step(1'b1, 1'b1);
    check("stuck_lock", 32'(locked), 32'd0);
    ph = 0;
    wave(7, 48, 1'b1);
    check("d7_duty", 32'(duty), 32'd7);

    // Reset mid-HIGH at duty 9, enable gap, then recovery
    ph = 0;
    wave(9, 34, 1'b1);
    apply_reset();
    wave(9, 6, 1'b1);
    wave(9, 10, 1'b0);
    wave(9, 48, 1'b1);
    check("d9_duty", 32'(duty), 32'd9);

    // Random mix
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 5))
        0, 1: wave(int'($urandom_range(0, 15)), int'($urandom_range(16, 48)), 1'b1);
        2: begin
          int per;
          per = int'($urandom_range(6, 24));
          irregular(per, int'($urandom_range(1, per - 1)));
        end
        3: wave(int'($urandom_range(0, 15)), int'($urandom_range(1, 12)), 1'b0);
        4: begin
          bit lvl;
          lvl = 1'($urandom_range(0, 1));
          for (int k = 0; k < int'($urandom_range(10, 40)); k++) do_step(lvl, 1'b1);
        end
        default: apply_reset();
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
